// File: rtl/wisc_pkg.sv
// Shared types and constants for the 16-bit pipelined CPU: opcodes, control
// bundle layouts and the decode-stage state encoding.
package wisc_pkg;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned REG_AW    = 4;
  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned WB_W      = 1;
  localparam int unsigned M_W       = 2;
  localparam int unsigned EX_W      = 10;
  localparam int unsigned ALU_SRC_W = 2;
  localparam int unsigned SHAMT_W   = 4;
  localparam int unsigned ALU_OP_W  = 4;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0, OP_SUB  = 4'h1, OP_NAND = 4'h2, OP_XOR  = 4'h3,
    OP_NOR  = 4'h4, OP_SRA  = 4'h5, OP_SRL  = 4'h6, OP_SLL  = 4'h7,
    OP_LW   = 4'h8, OP_SW   = 4'h9, OP_LHB  = 4'hA, OP_LLB  = 4'hB,
    OP_C    = 4'hC, OP_D    = 4'hD, OP_E    = 4'hE, OP_HLT  = 4'hF
  } opcode_t;

  localparam logic [ALU_SRC_W-1:0] ALU_SRC_REG    = 2'b00;
  localparam logic [ALU_SRC_W-1:0] ALU_SRC_IMM    = 2'b01;
  localparam logic [ALU_SRC_W-1:0] ALU_SRC_OFFSET = 2'b10;
  localparam logic [ALU_SRC_W-1:0] ALU_SRC_ONE    = 2'b11;

  localparam logic [M_W-1:0] M_READ  = 2'b10;
  localparam logic [M_W-1:0] M_WRITE = 2'b01;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  typedef struct packed {
    logic [ALU_SRC_W-1:0] alu_src;
    logic [SHAMT_W-1:0]   shamt;
    logic [ALU_OP_W-1:0]  alu_op;
  } ex_ctrl_t;

  typedef struct packed {
    logic                 valid;
    logic [WB_W-1:0]      wb;
    logic [M_W-1:0]       m;
    ex_ctrl_t             ctrl;
    logic [DATA_W-1:0]    reg0;
    logic [DATA_W-1:0]    reg1;
    logic [REG_AW-1:0]    rs;
    logic [REG_AW-1:0]    rt;
    logic [REG_AW-1:0]    rd;
    logic [DATA_W-1:0]    imm;
    logic [DATA_W-1:0]    offset;
    logic                 halt;
  } idex_t;

endpackage

// File: rtl/reg_file.sv
// 16x16 register file: two async read ports, one sync write port,
// R0 hard-wired to zero, write-to-read bypass within the same cycle.
module reg_file
  import wisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr0,
  input  logic [REG_AW-1:0] i_raddr1,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1
);

  logic [DATA_W-1:0] r_mem [NUM_REGS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_mem[i] <= '0;
    end else if (i_we && (i_waddr != '0)) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0 = (i_raddr0 == '0) ? '0 :
                    (i_we && (i_waddr == i_raddr0)) ? i_wdata : r_mem[i_raddr0];
  assign o_rdata1 = (i_raddr1 == '0) ? '0 :
                    (i_we && (i_waddr == i_raddr1)) ? i_wdata : r_mem[i_raddr1];

endmodule

// File: rtl/id_slice.sv
// Instruction-decode stage: decodes IF/ID into control bundles and operands,
// detects load-use hazards, handles halt, and registers the result into ID/EX.
module id_slice
  import wisc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_dst,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [WB_W-1:0]   ex_wb,
  output logic [M_W-1:0]    ex_m,
  output logic [EX_W-1:0]   ex_ctrl,
  output logic [DATA_W-1:0] ex_reg0,
  output logic [DATA_W-1:0] ex_reg1,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_imm,
  output logic [DATA_W-1:0] ex_offset,
  output logic              ex_halt
);

  state_t            r_state;
  state_t            w_state_nxt;
  idex_t             r_idex;
  idex_t             w_dec;
  idex_t             w_idex_d;
  opcode_t           w_op;
  logic [REG_AW-1:0] w_fa;
  logic [REG_AW-1:0] w_fb;
  logic [REG_AW-1:0] w_fc;
  logic [DATA_W-1:0] w_rdata0;
  logic [DATA_W-1:0] w_rdata1;
  logic              w_hazard;

  assign w_op = opcode_t'(if_instr[15:12]);
  assign w_fa = if_instr[11:8];
  assign w_fb = if_instr[7:4];
  assign w_fc = if_instr[3:0];

  // Unused source ports are left at address 0 so they never match a hazard.
  always_comb begin
    w_dec        = '0;
    w_dec.valid  = 1'b1;
    w_dec.imm    = {8'h00, if_instr[7:0]};
    w_dec.offset = {{11{w_fc[3]}}, w_fc, 1'b0};
    case (w_op)
      OP_ADD, OP_SUB, OP_NAND, OP_XOR, OP_NOR: begin
        w_dec.rd           = w_fa;
        w_dec.rs           = w_fb;
        w_dec.rt           = w_fc;
        w_dec.wb           = 1'b1;
        w_dec.ctrl.alu_src = ALU_SRC_REG;
        w_dec.ctrl.alu_op  = if_instr[15:12];
      end
      OP_SRA, OP_SRL, OP_SLL: begin
        w_dec.rd           = w_fa;
        w_dec.rs           = w_fb;
        w_dec.wb           = 1'b1;
        w_dec.ctrl.alu_src = ALU_SRC_REG;
        w_dec.ctrl.shamt   = w_fc;
        w_dec.ctrl.alu_op  = if_instr[15:12];
      end
      OP_LW: begin
        w_dec.rd           = w_fa;
        w_dec.rs           = w_fb;
        w_dec.wb           = 1'b1;
        w_dec.m            = M_READ;
        w_dec.ctrl.alu_src = ALU_SRC_OFFSET;
        w_dec.ctrl.alu_op  = OP_ADD;
      end
      OP_SW: begin
        w_dec.rs           = w_fb;
        w_dec.rt           = w_fa;
        w_dec.m            = M_WRITE;
        w_dec.ctrl.alu_src = ALU_SRC_OFFSET;
        w_dec.ctrl.alu_op  = OP_ADD;
      end
      OP_LHB, OP_LLB: begin
        w_dec.rd           = w_fa;
        w_dec.rs           = w_fa;
        w_dec.wb           = 1'b1;
        w_dec.ctrl.alu_src = ALU_SRC_IMM;
        w_dec.ctrl.alu_op  = if_instr[15:12];
      end
      default: w_dec = '0;
    endcase
  end

  reg_file u_reg_file (
    .clk      (clk),
    .rst      (rst),
    .i_we     (wb_we),
    .i_waddr  (wb_dst),
    .i_wdata  (wb_data),
    .i_raddr0 (w_dec.rs),
    .i_raddr1 (w_dec.rt),
    .o_rdata0 (w_rdata0),
    .o_rdata1 (w_rdata1)
  );

  assign w_hazard = r_idex.valid && r_idex.m[1] && (r_idex.rd != '0) &&
                    ((r_idex.rd == w_dec.rs) || (r_idex.rd == w_dec.rt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  // Next state, stall and the value loaded into ID/EX; flush outranks a hazard.
  always_comb begin
    w_state_nxt = r_state;
    stall_out   = 1'b0;
    w_idex_d    = '0;
    case (r_state)
      ST_RUN: begin
        if (if_valid && !flush) begin
          if (w_hazard) begin
            stall_out = 1'b1;
          end else if (w_op == OP_HLT) begin
            w_state_nxt   = ST_HALT;
            w_idex_d.halt = 1'b1;
          end else begin
            w_idex_d      = w_dec;
            w_idex_d.reg0 = w_rdata0;
            w_idex_d.reg1 = w_rdata1;
          end
        end
      end
      ST_HALT: begin
        stall_out     = 1'b1;
        w_idex_d.halt = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_idex <= '0;
    else     r_idex <= w_idex_d;
  end

  assign ex_valid  = r_idex.valid;
  assign ex_wb     = r_idex.wb;
  assign ex_m      = r_idex.m;
  assign ex_ctrl   = r_idex.ctrl;
  assign ex_reg0   = r_idex.reg0;
  assign ex_reg1   = r_idex.reg1;
  assign ex_rs     = r_idex.rs;
  assign ex_rt     = r_idex.rt;
  assign ex_rd     = r_idex.rd;
  assign ex_imm    = r_idex.imm;
  assign ex_offset = r_idex.offset;
  assign ex_halt   = r_idex.halt;

endmodule

// File: doc/id_slice.md
# id_slice

Instruction-decode stage of the 5-stage pipelined 16-bit CPU. It takes fetched instructions from IF/ID and decodes them into the WB/M/EX control bundles and operands consumed by the execute slice. It owns the 16×16 register file, written from the writeback port. It also detects load-use hazards, handles halt, and registers everything into the ID/EX pipeline register.

## Interface
Parameters:
- none; widths are fixed by the shared package.

Ports:
- `clk` in 1: clock, all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `if_valid` in 1: IF/ID holds a real instruction.
- `if_instr` in 16: instruction word.
- `flush` in 1: squash the instruction currently in decode (from branch logic).
- `wb_we` in 1: register-file write enable.
- `wb_dst` in 4: write address.
- `wb_data` in 16: write data.
- `stall_out` out 1: IF must hold its PC and IF/ID (combinational).
- `ex_valid` out 1: ID/EX holds a real instruction.
- `ex_wb` out 1: WB bundle, register write.
- `ex_m` out 2: M bundle, {mem_read, mem_write}.
- `ex_ctrl` out 10: EX bundle, {alu_src[9:8], shamt[7:4], alu_op[3:0]}.
- `ex_reg0` out 16: read port 0 data.
- `ex_reg1` out 16: read port 1 data.
- `ex_rs` out 4: port 0 address actually used; 0 if unused.
- `ex_rt` out 4: port 1 address actually used; 0 if unused.
- `ex_rd` out 4: destination register.
- `ex_imm` out 16: zero-extended imm8.
- `ex_offset` out 16: sign-extended imm4 << 1.
- `ex_halt` out 1: HLT reached ID/EX.

## Operation
- Opcode is `if_instr[15:12]`.
- R-type (0 ADD, 1 SUB, 2 NAND, 3 XOR, 4 NOR):
  - rd = [11:8], port0 = rs [7:4], port1 = rt [3:0].
  - alu_src = 00, wb = 1.
- Shift (5 SRA, 6 SRL, 7 SLL):
  - rd = [11:8], port0 = [7:4], shamt = [3:0].
  - port1 unused.
  - alu_src = 00, wb = 1.
- LW (8):
  - dest = [11:8], port0 = base [7:4].
  - alu_op = ADD, alu_src = 10, m = 10, wb = 1.
- SW (9):
  - port0 = base [7:4], port1 = data [11:8].
  - alu_op = ADD, alu_src = 10, m = 01, wb = 0, ex_rd = 0.
- LHB/LLB (A/B):
  - rd = port0 = [11:8], imm = {8'h00, [7:0]}.
  - alu_src = 01, wb = 1, alu_op = opcode.
- C/D/E (flow control, handled elsewhere):
  - decode to a bubble.
- HLT (F): see the state machine below.
- shamt = 0 for all non-shift instructions.
- Bubble: ex_valid, ex_wb, ex_m, ex_ctrl, ex_rd, ex_rs, ex_rt, ex_halt all 0.
- Register file:
  - R0 always reads 0; writes to R0 are ignored.
  - Write is synchronous.
  - Same-cycle write/read of the same non-zero address returns `wb_data` (internal bypass).
- Load-use hazard:
  - Condition: ex_valid && ex_m[1] && ex_rd≠0 && ex_rd matches a used source address of the decoding instruction.
  - Response: stall_out = 1 and a bubble is loaded into ID/EX.
  - The instruction is re-decoded the next cycle; this is exactly one stall cycle.
- `flush` has priority over a hazard:
  - a bubble is loaded and stall_out = 0;
  - flush during HALT has no effect.
- State machine RUN/HALT:
  - RUN→HALT when a valid, non-flushed, non-stalled HLT is decoded.
  - That cycle ID/EX loads a bubble with ex_halt = 1.
  - In HALT: every later cycle loads a bubble with ex_halt = 1, and stall_out = 1 constantly.
  - Only `rst` leaves HALT.
- `if_valid` = 0 loads a bubble; stall_out = 0 unless in HALT.

## Timing
- Decode and register read are combinational; ID/EX updates on the rising edge, so latency is 1 cycle.
- stall_out is combinational from ID/EX contents and `if_instr`, valid in the same cycle.
- Register-file write lands at the edge; the bypass covers the read in that same cycle.
- Reset, asserted at any time, including mid-stall or in HALT:
  - all ID/EX outputs 0;
  - all registers 0;
  - state RUN;
  - stall_out 0.
- On reset release the first decoded instruction appears at the outputs one edge later.

## Structure
- Shared package `wisc_pkg`:
  - opcode enum;
  - alu_src constants (00 REG, 01 IMM, 10 OFFSET, 11 ONE);
  - bundle widths (WB 1, M 2, EX 10);
  - RUN/HALT state enum.
- One sub-module, `reg_file`:
  - 16×16;
  - two asynchronous read ports, one synchronous write port;
  - R0 fixed at zero, internal bypass.
- Decode, hazard detection and the ID/EX register live in `id_slice`.

## Test plan
- Write R3 = 0x1234 and R4 = 0x0FFF via the WB port, then decode 0x0534 (ADD R5,R3,R4) → next edge: ex_reg0 = 0x1234, ex_reg1 = 0x0FFF, ex_ctrl = 10'h000, ex_wb = 1, ex_rd = 5, ex_rs = 3, ex_rt = 4.
- Decode LW 0x82FE (R2 ← [R15 + offset]) → ex_offset = 0xFFFC, ex_m = 10, alu_src = 10, ex_rd = 2. Then decode 0x1623 (SUB R6,R2,R3) → stall_out = 1 and one bubble, then SUB issues with ex_rs = 2.
- Assert wb_we with wb_dst = 7, wb_data = 0xBEEF while decoding 0x3170 (XOR R1,R7,R0) → ex_reg0 = 0xBEEF, ex_reg1 = 0. A write of 0xFFFF to R0 afterwards still reads 0.
- Decode 0xF000 (HLT) → ex_halt = 1, stall_out stays 1, and later instructions produce bubbles. Assert rst → all outputs 0 and state RUN.
- Raise flush together with a load-use hazard → bubble loaded, stall_out = 0. Decode 0xA9C3 (LHB R9) → ex_imm = 0x00C3, alu_src = 01, ex_rs = 9.
